// File: rtl/dport_pkg.sv
// dport_pkg: shared data-port widths and request decode.
package dport_pkg;
  localparam int TAG_W  = 11;
  localparam int DATA_W = 32;
  function automatic logic cpu_req(input logic rd, input logic [3:0] wr, input logic flush,
                                   input logic inv, input logic wb);
    return rd | (|wr) | flush | inv | wb;
  endfunction
endpackage

// File: rtl/dport_tcm_resp_if.sv
// dport_tcm_resp_if: CPU data-port request/response bundle.
interface dport_tcm_resp_if;
  import dport_pkg::*;
  logic [DATA_W-1:0] addr, data_wr, data_rd;
  logic [3:0]        wr;
  logic [TAG_W-1:0]  req_tag, resp_tag;
  logic              rd, cacheable, invalidate, writeback, flush, accept, ack, error;
  modport master (output addr, data_wr, rd, wr, cacheable, req_tag, invalidate, writeback, flush,
                  input data_rd, accept, ack, error, resp_tag);
  modport slave  (input addr, data_wr, rd, wr, cacheable, req_tag, invalidate, writeback, flush,
                  output data_rd, accept, ack, error, resp_tag);
endinterface

// File: rtl/tcm_ext_arb.sv
// tcm_ext_arb: CPU-priority RAM arbiter with a bounded wait for the external port.
module tcm_ext_arb #(
  parameter int unsigned EXT_STARVE = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cpu_req_i,
  input  logic ext_req_i,
  output logic ext_gnt_o
);
  logic [3:0] starve_q, starve_d;
  assign ext_gnt_o = ext_req_i & (~cpu_req_i | starve_q == 4'(EXT_STARVE));
  always_comb
    starve_d = (ext_req_i & ~ext_gnt_o)
             ? (starve_q == 4'(EXT_STARVE) ? starve_q : starve_q + 4'd1) : 4'd0;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) starve_q <= 4'd0;
    else       starve_q <= starve_d;
endmodule

// File: rtl/dport_tcm_resp.sv
// dport_tcm_resp: TCM responder for the CPU dport, sharing a 1-cycle RAM with an external port.
module dport_tcm_resp
  import dport_pkg::*;
#(
  parameter logic [31:0] TCM_MEM_BASE = 32'h0,
  parameter int unsigned TCM_MEM_SIZE = 65536,
  parameter int unsigned EXT_STARVE   = 4,
  localparam int AW = $clog2(TCM_MEM_SIZE / 4)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dport_tcm_resp_if.slave       dport,
  input  logic                  ext_req_i,
  input  logic                  ext_we_i,
  input  logic [AW-1:0]         ext_addr_i,
  input  logic [DATA_W-1:0]     ext_data_wr_i,
  output logic                  ext_gnt_o,
  output logic                  ext_ack_o,
  output logic [DATA_W-1:0]     ext_data_rd_o,
  output logic [AW-1:0]         ram_addr_o,
  output logic                  ram_rd_o,
  output logic [3:0]            ram_wr_o,
  output logic [DATA_W-1:0]     ram_data_wr_o,
  input  logic [DATA_W-1:0]     ram_data_rd_i
);
  logic             cpu_req_w, in_range_w, cpu_acc_w, cpu_ram_w, unused_w;
  logic [31:0]      offset_w;
  logic             resp_valid_q, resp_valid_d, resp_rd_q, resp_rd_d, resp_err_q, resp_err_d;
  logic             ext_valid_q, ext_valid_d, ext_rd_q, ext_rd_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  assign cpu_req_w  = cpu_req(dport.rd, dport.wr, dport.flush, dport.invalidate, dport.writeback);
  assign offset_w   = dport.addr - TCM_MEM_BASE;
  assign in_range_w = dport.addr >= TCM_MEM_BASE && offset_w < 32'(TCM_MEM_SIZE);
  assign unused_w   = ^{dport.cacheable, offset_w[1:0], offset_w[31:AW+2]};
  tcm_ext_arb #(.EXT_STARVE(EXT_STARVE)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cpu_req_i (cpu_req_w),
    .ext_req_i (ext_req_i),
    .ext_gnt_o (ext_gnt_o)
  );
  assign dport.accept = ~ext_gnt_o;
  assign cpu_acc_w    = cpu_req_w & ~ext_gnt_o;
  assign cpu_ram_w    = cpu_acc_w & in_range_w;
  always_comb begin
    ram_addr_o    = ext_gnt_o ? ext_addr_i : offset_w[AW+1:2];
    ram_rd_o      = ext_gnt_o ? ~ext_we_i : cpu_ram_w & dport.rd;
    ram_wr_o      = ext_gnt_o ? {4{ext_we_i}} : (cpu_ram_w ? dport.wr : 4'd0);
    ram_data_wr_o = ext_gnt_o ? ext_data_wr_i : dport.data_wr;
  end
  // Maintenance ops never touch the RAM, so only data accesses can fault on range
  always_comb begin
    resp_valid_d = cpu_acc_w;
    resp_rd_d    = cpu_ram_w & dport.rd;
    resp_err_d   = cpu_acc_w & ~in_range_w & (dport.rd | (|dport.wr));
    resp_tag_d   = cpu_acc_w ? dport.req_tag : resp_tag_q;
    ext_valid_d  = ext_gnt_o;
    ext_rd_d     = ext_gnt_o & ~ext_we_i;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_rd_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_tag_q   <= '0;
      ext_valid_q  <= 1'b0;
      ext_rd_q     <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
      resp_tag_q   <= resp_tag_d;
      ext_valid_q  <= ext_valid_d;
      ext_rd_q     <= ext_rd_d;
    end
  assign dport.ack      = resp_valid_q;
  assign dport.error    = resp_err_q;
  assign dport.resp_tag = resp_tag_q;
  assign dport.data_rd  = resp_rd_q ? ram_data_rd_i : '0;
  assign ext_ack_o      = ext_valid_q;
  assign ext_data_rd_o  = ext_rd_q ? ram_data_rd_i : '0;
endmodule

// File: tb/tb_dport_tcm_resp.sv
// tb_dport_tcm_resp: random + directed checks of dport_tcm_resp against a cycle-level reference.
module tb_dport_tcm_resp;
  localparam int AW = 14, STARVE = 4, NW = 64;
  logic clk_i = 1'b0, rst_i = 1'b1;
  always #5 clk_i = ~clk_i;
  dport_tcm_resp_if dp();
  logic ext_req_i, ext_we_i, ext_gnt_o, ext_ack_o, ram_rd_o;
  logic [AW-1:0] ext_addr_i, ram_addr_o;
  logic [31:0] ext_data_wr_i, ext_data_rd_o, ram_data_wr_o, ram_data_rd_i;
  logic [3:0] ram_wr_o;
  dport_tcm_resp dut (
    .clk_i(clk_i), .rst_i(rst_i), .dport(dp.slave),
    .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
    .ext_data_wr_i(ext_data_wr_i), .ext_gnt_o(ext_gnt_o), .ext_ack_o(ext_ack_o),
    .ext_data_rd_o(ext_data_rd_o), .ram_addr_o(ram_addr_o), .ram_rd_o(ram_rd_o),
    .ram_wr_o(ram_wr_o), .ram_data_wr_o(ram_data_wr_o), .ram_data_rd_i(ram_data_rd_i)
  );
  logic [31:0] ram [2**AW];
  always @(posedge clk_i) begin
    if (ram_rd_o) ram_data_rd_i <= ram[ram_addr_o];
    for (int b = 0; b < 4; b++)
      if (ram_wr_o[b]) ram[ram_addr_o][8*b +: 8] <= ram_data_wr_o[8*b +: 8];
  end
  logic [31:0] ref_mem [NW];
  int errs = 0, checks = 0, ext_wait = 0, cyc = 0;
  logic gnt_seen, acc_seen;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic idle();
    dp.addr = '0; dp.data_wr = '0; dp.rd = 0; dp.wr = '0; dp.cacheable = 0;
    dp.req_tag = '0; dp.invalidate = 0; dp.writeback = 0; dp.flush = 0;
  endtask
  // One clock of the reference: arbitration, RAM drive, then the responses one cycle later
  task automatic step();
    logic cpu, inr, gnt, e_ack, e_err, e_xack, e_rd;
    logic [3:0] e_wr;
    logic [10:0] e_tag;
    logic [31:0] e_data, e_xdata, w;
    int wa;
    #1;
    cpu = dp.rd || dp.wr != 0 || dp.flush || dp.invalidate || dp.writeback;
    inr = dp.addr < 32'h10000;
    wa  = int'(dp.addr[AW+1:2]);
    gnt = ext_req_i && (!cpu || ext_wait >= STARVE);
    check("ext_gnt", 32'(ext_gnt_o), 32'(gnt));
    check("accept", 32'(dp.accept), 32'(!gnt));
    e_rd = gnt ? !ext_we_i : cpu && inr && dp.rd;
    e_wr = gnt ? {4{ext_we_i}} : (cpu && inr ? dp.wr : 4'd0);
    check("ram_rd", 32'(ram_rd_o), 32'(e_rd));
    check("ram_wr", 32'(ram_wr_o), 32'(e_wr));
    if (e_rd || e_wr != 0) check("ram_addr", 32'(ram_addr_o), gnt ? 32'(ext_addr_i) : 32'(wa));
    if (e_wr != 0) check("ram_wdata", ram_data_wr_o, gnt ? ext_data_wr_i : dp.data_wr);
    e_ack   = cpu && !gnt;
    e_err   = e_ack && !inr && (dp.rd || dp.wr != 0);
    e_tag   = dp.req_tag;
    e_data  = (e_ack && inr && dp.rd) ? ref_mem[wa] : 32'd0;
    e_xack  = gnt;
    e_xdata = (gnt && !ext_we_i) ? ref_mem[ext_addr_i] : 32'd0;
    if (gnt && ext_we_i) ref_mem[ext_addr_i] = ext_data_wr_i;
    else if (e_ack && inr) begin
      w = ref_mem[wa];
      for (int b = 0; b < 4; b++) if (dp.wr[b]) w[8*b +: 8] = dp.data_wr[8*b +: 8];
      ref_mem[wa] = w;
    end
    ext_wait = (ext_req_i && !gnt) ? ext_wait + 1 : 0;
    gnt_seen = gnt;
    acc_seen = dp.accept;
    @(posedge clk_i); #1;
    cyc++;
    check("ack", 32'(dp.ack), 32'(e_ack));
    check("error", 32'(dp.error), 32'(e_err));
    check("rdata", dp.data_rd, e_data);
    if (e_ack) check("tag", 32'(dp.resp_tag), 32'(e_tag));
    check("ext_ack", 32'(ext_ack_o), 32'(e_xack));
    check("ext_rdata", ext_data_rd_o, e_xdata);
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"}, 32'(dp.ack), 0);
    check({tag, "_err"}, 32'(dp.error), 0);
    check({tag, "_tag"}, 32'(dp.resp_tag), 0);
    check({tag, "_rdata"}, dp.data_rd, 0);
    check({tag, "_xack"}, 32'(ext_ack_o), 0);
    check({tag, "_xdata"}, ext_data_rd_o, 0);
  endtask
  initial begin
    int gnt_at, acc_low, r;
    idle();
    ext_req_i = 0; ext_we_i = 0; ext_addr_i = '0; ext_data_wr_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_vals("reset");
    rst_i = 0;
    for (int i = 0; i < NW; i++) begin
      idle(); dp.addr = 32'(i * 4); dp.wr = 4'hF;
      dp.data_wr = (i == 4) ? 32'hDEADBEEF : (i == 2) ? 32'hAABBCCDD : (i == 7) ? 32'h77777777 : $urandom;
      step();
    end
    idle(); dp.addr = 32'h10; dp.rd = 1; dp.req_tag = 11'h155; step();
    check("t1_data", dp.data_rd, 32'hDEADBEEF);
    check("t1_tag", 32'(dp.resp_tag), 32'h155);
    idle(); dp.addr = 32'h8; dp.wr = 4'b0101; dp.data_wr = 32'h11223344; step();
    idle(); dp.addr = 32'h8; dp.rd = 1; step();
    check("t2_merge", dp.data_rd, 32'hAA22CC44);
    idle(); dp.addr = 32'h0001_0000; dp.rd = 1; step();
    check("t3_err", 32'(dp.error), 1);
    for (int t = 1; t <= 4; t++) begin
      idle(); dp.addr = 32'(t * 4); dp.rd = 1; dp.req_tag = 11'(t); step();
      check("b2b_tag", 32'(dp.resp_tag), 32'(t));
    end
    idle(); dp.addr = 32'h20; dp.flush = 1; step();
    gnt_at = -1; acc_low = 0;
    for (int i = 0; i < 20; i++) begin
      idle(); dp.addr = 32'($urandom_range(0, NW - 1) * 4); dp.rd = 1;
      if (i == 10) begin ext_req_i = 1; ext_we_i = 0; ext_addr_i = 14'd7; end
      step();
      if (!acc_seen) acc_low++;
      if (gnt_seen) begin
        gnt_at = i; ext_req_i = 0;
        check("starve_xdata", ext_data_rd_o, ref_mem[7]);
      end
    end
    check("starve_gnt_cycle", 32'(gnt_at), 14);
    check("starve_accept_low", 32'(acc_low), 1);
    for (int i = 0; i < 500; i++) begin
      idle(); r = $urandom_range(0, 9);
      dp.addr = 32'($urandom_range(0, NW - 1) * 4 + $urandom_range(0, 3));
      dp.req_tag = 11'($urandom);
      dp.data_wr = $urandom;
      if (r < 3) dp.rd = 1;
      else if (r < 5) dp.wr = 4'($urandom_range(1, 15));
      else if (r == 5) {dp.flush, dp.invalidate, dp.writeback} = 3'b001 << $urandom_range(0, 2);
      else if (r == 6) begin
        dp.addr = 32'h0001_0000 + $urandom_range(0, 32'h00FF_FFFF);
        if ($urandom_range(0, 1) == 1) dp.rd = 1; else dp.wr = 4'hF;
      end
      if (!ext_req_i && $urandom_range(0, 3) == 0) begin
        ext_req_i = 1; ext_we_i = 1'($urandom_range(0, 1));
        ext_addr_i = 14'($urandom_range(0, NW - 1)); ext_data_wr_i = $urandom;
      end
      step();
      if (gnt_seen) ext_req_i = 0;
    end
    idle(); ext_req_i = 0;
    dp.addr = 32'h10; dp.rd = 1; dp.req_tag = 11'h2A; step();
    rst_i = 1; #1;
    check("async_ack_drop", 32'(dp.ack), 0);
    rst_i = 0; ext_wait = 0;
    idle(); dp.addr = 32'h14; dp.rd = 1; dp.req_tag = 11'h3B;
    #2; rst_i = 1; idle();
    @(posedge clk_i); #1;
    check_reset_vals("rst_inflight");
    @(posedge clk_i); #1;
    rst_i = 0;
    @(posedge clk_i); #1;
    check_reset_vals("post_rst");
    idle(); dp.addr = 32'h10; dp.rd = 1; dp.req_tag = 11'h7FF; step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
